// File: rtl/four_bit_serial_subtractor_if.sv
// Request/result bundle for the bit-serial subtractor: operands and start
// flow from the requester, result and status flow back.
interface four_bit_serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             start;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             busy;
  logic             done;

  modport master (
    output a, b, bin, start,
    input  diff, bout, busy, done
  );

  modport slave (
    input  a, b, bin, start,
    output diff, bout, busy, done
  );
endinterface

// File: rtl/four_bit_serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// and publishes {bout, diff} together with a one-cycle done pulse.
module four_bit_serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  four_bit_serial_subtractor_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic d_bit;
  logic br_nx;

  // One full-subtractor cell, fed from the LSB of the operand shifters.
  assign d_bit = a_q[0] ^ b_q[0] ^ br_q;
  assign br_nx = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      acc_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      acc_q   <= acc_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    acc_d   = acc_q;
    diff_d  = diff_q;
    bout_d  = bout_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          br_d    = bus.bin;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Result bits enter at the MSB so the word is aligned after WIDTH shifts.
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        br_d  = br_nx;
        acc_d = {d_bit, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + ONE;
        if (cnt_q == LAST) begin
          diff_d  = {d_bit, acc_q[WIDTH-1:1]};
          bout_d  = br_nx;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);

endmodule

// File: doc/four_bit_serial_subtractor.md
FOUR_BIT_SERIAL_SUBTRACTOR -- requirements
Module: four_bit_serial_subtractor

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 4, operand/result bit width (legal range 2..16).
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 Port clk  input  1  rising-edge clock for all state.
REQ-004 Port rst  input  1  synchronous active-high reset.
REQ-005 Port a  input  WIDTH  minuend, sampled only when a request is accepted.
REQ-006 Port b  input  WIDTH  subtrahend, sampled only when a request is accepted.
REQ-007 Port bin  input  1  borrow-in, sampled only when a request is accepted.
REQ-008 Port start  input  1  request strobe, level-sampled each clock edge.
REQ-009 Port diff  output  WIDTH  registered result (a - b - bin) mod 2^WIDTH.
REQ-010 Port bout  output  1  registered borrow-out, 1 iff a < b + bin (unsigned).
REQ-011 Port busy  output  1  high while state is RUN or DONE.
REQ-012 Port done  output  1  high for exactly one cycle when a new result is valid.

Function
REQ-013 The block SHALL implement FSM states IDLE, RUN, DONE, each held in registers.
REQ-014 In IDLE, a rising edge with start=1 SHALL be the accept edge N: latch a, b, bin into internal shift/borrow registers, clear bit counter, go to RUN.
REQ-015 In RUN, each edge SHALL process one bit, LSB first: d_i = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
REQ-016 Edges N+1 .. N+WIDTH SHALL process bits 0 .. WIDTH-1; the counter SHALL be sized ceil(log2(WIDTH))+1 bits and SHALL NOT wrap during an operation.
REQ-017 At edge N+WIDTH, diff and bout SHALL update to the final result, state SHALL go to DONE, and done SHALL read 1 during the following cycle.
REQ-018 At edge N+WIDTH+1, DONE SHALL go to IDLE unconditionally; done SHALL return to 0.
REQ-019 start SHALL be ignored in RUN and DONE; operand changes after edge N SHALL NOT affect the result.
REQ-020 With start held high continuously, the next request SHALL be accepted at edge N+WIDTH+2 (throughput one op per WIDTH+2 cycles).
REQ-021 diff and bout SHALL hold their last completed values until the next completion; they SHALL NOT show partial results during RUN.
REQ-022 Results SHALL be bit-exact with {bout, diff} = {1'b0, a} - b - bin in WIDTH+1-bit two's complement, bout taken as the sign bit.

Reset
REQ-023 rst=1 at an edge SHALL force state IDLE, diff=0, bout=0, busy=0, done=0, counter and internal registers to 0.
REQ-024 Reset SHALL take priority over start and over any in-progress operation; an aborted operation SHALL produce no done pulse.
REQ-025 The first request SHALL be acceptable on the first edge with rst=0 and start=1.

Verification (WIDTH=4)
REQ-026 a=9, b=3, bin=0, start pulse at edge N -> diff=6, bout=0, done=1 only in the cycle after edge N+4, busy=1 from after N to after N+5.
REQ-027 a=3, b=9, bin=0 -> diff=0xA, bout=1; a=0, b=0, bin=1 -> diff=0xF, bout=1; a=15, b=15, bin=0 -> diff=0, bout=0.
REQ-028 Accept a=5, b=2, bin=0; at N+2 assert start with a=1, b=7 -> result diff=3, bout=0; second request not accepted until IDLE.
REQ-029 start held high with fixed a=8, b=1, bin=1 -> done pulses exactly every 6 cycles, diff=6, bout=0 each time.
REQ-030 Accept a=12, b=4, then rst=1 at edge N+2 -> all outputs 0, state IDLE, no done pulse; a subsequent request completes correctly.
REQ-031 Exhaustive sweep of all 512 (a, b, bin) combinations -> every {bout, diff} matches REQ-022.
